// File: rtl/nvme_pcie_pkg.sv
// Shared PCIe/NVMe definitions: FSM states, request types,
// doorbell offsets and RQ descriptor field positions.
package nvme_pcie_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DESC,
    ST_DATA,
    ST_DONE
  } dbl_state_e;

  localparam logic [3:0]  REQ_TYPE_MEMWR  = 4'b0001;
  localparam logic [63:0] NVME_DBL_OFFSET = 64'h1000;

  localparam int DESC_ADDR_LSB    = 0;
  localparam int DESC_DWCNT_LSB   = 64;
  localparam int DESC_DWCNT_W     = 11;
  localparam int DESC_REQTYPE_LSB = 75;
  localparam int DESC_REQID_LSB   = 80;
  localparam int DESC_TAG_LSB     = 96;

  function automatic logic [63:0] dbl_addr(
    logic [63:0] base,
    int unsigned idx,
    int unsigned dstrd
  );
    return base + NVME_DBL_OFFSET + (64'(idx) << (2 + dstrd));
  endfunction

endpackage

// File: rtl/rq_mwr_desc.sv
// Builds the 128-bit RQ descriptor of a Memory Write request.
// Tag, TC, attributes and poison are all left at zero.
module rq_mwr_desc
  import nvme_pcie_pkg::*;
(
  input  logic [63:0]  addr_i,
  input  logic [10:0]  dw_cnt_i,
  input  logic [15:0]  req_id_i,
  output logic [127:0] desc_o
);

  // Pack the fields; address is forced DW-aligned
  always_comb begin
    desc_o = '0;
    desc_o[DESC_ADDR_LSB +: 64] = addr_i & ~64'd3;
    desc_o[DESC_DWCNT_LSB +: DESC_DWCNT_W] = dw_cnt_i;
    desc_o[DESC_REQTYPE_LSB +: 4] = REQ_TYPE_MEMWR;
    desc_o[DESC_REQID_LSB +: 16] = req_id_i;
  end

endmodule

// File: rtl/nvme_dbl_writer.sv
// Turns SQ-tail / CQ-head doorbell requests into 1-DW
// Memory Write TLPs on the PCIe RQ stream.
module nvme_dbl_writer
  import nvme_pcie_pkg::*;
#(
  parameter int          C_DATA_WIDTH        = 128,
  parameter int          KEEP_WIDTH          = C_DATA_WIDTH / 32,
  parameter int          AXI4_RQ_TUSER_WIDTH = 62,
  parameter logic [63:0] BAR0_BASE           = 64'h0000_0000_F700_0000,
  parameter int          DSTRD               = 0,
  parameter int          QID                 = 0,
  parameter logic [15:0] REQ_ID              = 16'h0000
) (
  input  logic                           user_clk,
  input  logic                           user_reset_n,
  input  logic                           user_lnk_up,
  input  logic                           write_sqtdbl,
  input  logic [63:0]                    sqt_addr,
  input  logic                           write_cqhdbl,
  input  logic [63:0]                    cqh_addr,
  output logic                           write_sqtdbl_done,
  output logic                           write_cqhdbl_done,
  output logic [C_DATA_WIDTH-1:0]        s_axis_rq_tdata,
  output logic [KEEP_WIDTH-1:0]          s_axis_rq_tkeep,
  output logic                           s_axis_rq_tlast,
  output logic [AXI4_RQ_TUSER_WIDTH-1:0] s_axis_rq_tuser,
  output logic                           s_axis_rq_tvalid,
  input  logic                           s_axis_rq_tready,
  output logic                           dbl_busy
);

  localparam int unsigned SQ_IDX = 2 * QID;
  localparam int unsigned CQ_IDX = 2 * QID + 1;
  localparam logic [63:0] SQ_DBL = dbl_addr(BAR0_BASE, SQ_IDX, DSTRD);
  localparam logic [63:0] CQ_DBL = dbl_addr(BAR0_BASE, CQ_IDX, DSTRD);

  dbl_state_e  state_q, state_d;
  logic        sq_pend_q, sq_pend_d;
  logic        cq_pend_q, cq_pend_d;
  logic [15:0] sq_val_q, sq_val_d;
  logic [15:0] cq_val_q, cq_val_d;
  logic [15:0] val_q, val_d;
  logic        is_cq_q, is_cq_d;
  logic [127:0] desc;
  logic        unused_ok;

  assign unused_ok = ^{sqt_addr[63:16], cqh_addr[63:16]};

  rq_mwr_desc u_desc (
    .addr_i   (is_cq_q ? CQ_DBL : SQ_DBL),
    .dw_cnt_i (11'd1),
    .req_id_i (REQ_ID),
    .desc_o   (desc)
  );

  // State, pending flags and latched doorbell values
  always_ff @(posedge user_clk or negedge user_reset_n) begin
    if (!user_reset_n) begin
      state_q   <= ST_IDLE;
      sq_pend_q <= 1'b0;
      cq_pend_q <= 1'b0;
      sq_val_q  <= '0;
      cq_val_q  <= '0;
      val_q     <= '0;
      is_cq_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      sq_pend_q <= sq_pend_d;
      cq_pend_q <= cq_pend_d;
      sq_val_q  <= sq_val_d;
      cq_val_q  <= cq_val_d;
      val_q     <= val_d;
      is_cq_q   <= is_cq_d;
    end
  end

  // Capture requests, arbitrate SQ over CQ, walk the TLP beats
  always_comb begin
    state_d   = state_q;
    sq_pend_d = sq_pend_q;
    cq_pend_d = cq_pend_q;
    sq_val_d  = sq_val_q;
    cq_val_d  = cq_val_q;
    val_d     = val_q;
    is_cq_d   = is_cq_q;
    if (write_sqtdbl) begin
      sq_pend_d = 1'b1;
      sq_val_d  = sqt_addr[15:0];
    end
    if (write_cqhdbl) begin
      cq_pend_d = 1'b1;
      cq_val_d  = cqh_addr[15:0];
    end
    unique case (state_q)
      ST_IDLE: begin
        if (sq_pend_d) begin
          state_d   = ST_DESC;
          is_cq_d   = 1'b0;
          val_d     = sq_val_d;
          sq_pend_d = 1'b0;
        end else if (cq_pend_d) begin
          state_d   = ST_DESC;
          is_cq_d   = 1'b1;
          val_d     = cq_val_d;
          cq_pend_d = 1'b0;
        end
      end
      ST_DESC: if (s_axis_rq_tready) state_d = ST_DATA;
      ST_DATA: if (s_axis_rq_tready) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (!user_lnk_up) begin
      state_d   = ST_IDLE;
      sq_pend_d = 1'b0;
      cq_pend_d = 1'b0;
      sq_val_d  = '0;
      cq_val_d  = '0;
      val_d     = '0;
      is_cq_d   = 1'b0;
    end
  end

  // RQ beat outputs, decoded purely from registered state
  always_comb begin
    s_axis_rq_tdata  = '0;
    s_axis_rq_tkeep  = '0;
    s_axis_rq_tlast  = 1'b0;
    s_axis_rq_tuser  = '0;
    s_axis_rq_tvalid = 1'b0;
    if (state_q == ST_DESC) begin
      s_axis_rq_tdata[127:0] = desc;
      s_axis_rq_tkeep  = KEEP_WIDTH'(4'hF);
      s_axis_rq_tuser  = AXI4_RQ_TUSER_WIDTH'(8'h0F);
      s_axis_rq_tvalid = 1'b1;
    end else if (state_q == ST_DATA) begin
      s_axis_rq_tdata[31:0] = {16'h0, val_q};
      s_axis_rq_tkeep  = KEEP_WIDTH'(4'h1);
      s_axis_rq_tlast  = 1'b1;
      s_axis_rq_tuser  = AXI4_RQ_TUSER_WIDTH'(8'h0F);
      s_axis_rq_tvalid = 1'b1;
    end
  end

  assign write_sqtdbl_done = (state_q == ST_DONE) && !is_cq_q;
  assign write_cqhdbl_done = (state_q == ST_DONE) && is_cq_q;
  assign dbl_busy = (state_q != ST_IDLE) || sq_pend_q || cq_pend_q;

endmodule

// File: tb/tb_nvme_dbl_writer.sv
// Directed bench for nvme_dbl_writer: TLP contents, ordering,
// stalls, coalescing, doorbell stride, reset and flush.
module tb_nvme_dbl_writer;

  typedef struct {
    logic [127:0] d;
    logic [3:0]   k;
    logic         l;
    logic [61:0]  u;
    int           c;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, lnk, tready;
  logic         wsq, wcq;
  logic [63:0]  sqa, cqa;
  logic         sq_done, cq_done, tlast, tvalid, busy;
  logic [127:0] tdata;
  logic [3:0]   tkeep;
  logic [61:0]  tuser;
  logic         sq_done2, cq_done2, tlast2, tvalid2, busy2;
  logic [127:0] tdata2;
  logic [3:0]   tkeep2;
  logic [61:0]  tuser2;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  beat_t       beats[$];
  int          done_q[$];
  int          done_c[$];
  logic [63:0] addr2_q[$];

  nvme_dbl_writer u_dut (
    .user_clk          (clk),
    .user_reset_n      (rst_n),
    .user_lnk_up       (lnk),
    .write_sqtdbl      (wsq),
    .sqt_addr          (sqa),
    .write_cqhdbl      (wcq),
    .cqh_addr          (cqa),
    .write_sqtdbl_done (sq_done),
    .write_cqhdbl_done (cq_done),
    .s_axis_rq_tdata   (tdata),
    .s_axis_rq_tkeep   (tkeep),
    .s_axis_rq_tlast   (tlast),
    .s_axis_rq_tuser   (tuser),
    .s_axis_rq_tvalid  (tvalid),
    .s_axis_rq_tready  (tready),
    .dbl_busy          (busy)
  );

  nvme_dbl_writer #(.DSTRD(2), .QID(1)) u_dut2 (
    .user_clk          (clk),
    .user_reset_n      (rst_n),
    .user_lnk_up       (lnk),
    .write_sqtdbl      (wsq),
    .sqt_addr          (sqa),
    .write_cqhdbl      (wcq),
    .cqh_addr          (cqa),
    .write_sqtdbl_done (sq_done2),
    .write_cqhdbl_done (cq_done2),
    .s_axis_rq_tdata   (tdata2),
    .s_axis_rq_tkeep   (tkeep2),
    .s_axis_rq_tlast   (tlast2),
    .s_axis_rq_tuser   (tuser2),
    .s_axis_rq_tvalid  (tvalid2),
    .s_axis_rq_tready  (tready),
    .dbl_busy          (busy2)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (tvalid && tready)
      beats.push_back('{tdata, tkeep, tlast, tuser, cyc});
    if (tvalid2 && tready && tkeep2 == 4'hF)
      addr2_q.push_back(tdata2[63:0]);
    if (sq_done) begin
      done_q.push_back(1);
      done_c.push_back(cyc);
    end
    if (cq_done) begin
      done_q.push_back(2);
      done_c.push_back(cyc);
    end
  end

  task automatic check(string tag, logic [127:0] got,
                       logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear();
    beats.delete();
    done_q.delete();
    done_c.delete();
    addr2_q.delete();
  endtask

  task automatic req(logic s, logic c,
                     logic [15:0] sv, logic [15:0] cv);
    wsq = s;
    wcq = c;
    sqa = {48'hABCD_0000_1234, sv};
    cqa = {48'h5555_0000_9876, cv};
    tick(1);
    wsq = 1'b0;
    wcq = 1'b0;
  endtask

  task automatic wait_beats(string tag, int n);
    int t = 0;
    while (beats.size() < n && t < 200) begin
      @(negedge clk);
      t++;
    end
    check(tag, 128'(beats.size()), 128'(n));
  endtask

  task automatic settle(string tag);
    int t = 0;
    while ((busy || busy2) && t < 200) begin
      @(posedge clk);
      t++;
    end
    #1;
    check(tag, {busy, busy2}, 2'b00);
    tick(3);
  endtask

  function automatic logic [127:0] bd(int i);
    return (beats.size() > i) ? beats[i].d : '1;
  endfunction

  function automatic int dq(int i);
    return (done_q.size() > i) ? done_q[i] : -1;
  endfunction

  initial begin
    int k;
    logic stable;
    logic [127:0] sd;
    logic [3:0] sk;
    logic sl;
    rst_n = 1'b0;
    lnk = 1'b1;
    tready = 1'b1;
    wsq = 1'b0;
    wcq = 1'b0;
    sqa = '0;
    cqa = '0;
    tick(3);
    check("rst_valid", tvalid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", {sq_done, cq_done}, 0);
    check("rst_data", tdata, 0);
    rst_n = 1'b1;
    tick(2);

    // single SQ doorbell
    clear();
    k = cyc;
    req(1, 0, 16'h0003, 0);
    wait_beats("t1_nbeats", 2);
    tick(4);
    check("t1_addr", bd(0) & 128'hFFFF_FFFF_FFFF_FFFF,
          128'hF700_1000);
    check("t1_type", bd(0) >> 75 & 128'hF, 1);
    check("t1_dwcnt", bd(0) >> 64 & 128'h7FF, 1);
    check("t1_hi", bd(0) >> 79, 0);
    check("t1_k0", beats[0].k, 4'hF);
    check("t1_l0", beats[0].l, 0);
    check("t1_u0", beats[0].u, 62'hF);
    check("t1_lat0", beats[0].c - k, 1);
    check("t1_data", bd(1), 128'h3);
    check("t1_k1", beats[1].k, 4'h1);
    check("t1_l1", beats[1].l, 1);
    check("t1_u1", beats[1].u, 62'hF);
    check("t1_ndone", done_q.size(), 1);
    check("t1_dtype", dq(0), 1);
    check("t1_dlat", (done_c.size() > 0) ? done_c[0] - k : -1, 3);

    // simultaneous SQ and CQ; second DUT checks stride
    clear();
    req(1, 1, 16'h0005, 16'h0007);
    wait_beats("t2_nbeats", 4);
    settle("t2_idle");
    check("t2_a0", bd(0) & 128'hFFFF_FFFF, 128'hF700_1000);
    check("t2_d0", bd(1), 5);
    check("t2_a1", bd(2) & 128'hFFFF_FFFF, 128'hF700_1004);
    check("t2_d1", bd(3), 7);
    check("t2_ndone", done_q.size(), 2);
    check("t2_first", dq(0), 1);
    check("t2_second", dq(1), 2);
    check("t2_n2", addr2_q.size(), 2);
    check("t2_sq2",
          (addr2_q.size() > 0) ? addr2_q[0] : '1, 64'hF700_1020);
    check("t2_cq2",
          (addr2_q.size() > 1) ? addr2_q[1] : '1, 64'hF700_1030);

    // back-pressure on both beats
    clear();
    tready = 1'b0;
    req(1, 0, 16'h00A5, 0);
    check("t3_valid", tvalid, 1);
    sd = tdata;
    sk = tkeep;
    sl = tlast;
    stable = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (tdata !== sd || tkeep !== sk || tlast !== sl || !tvalid)
        stable = 1'b0;
    end
    check("t3_stable0", stable, 1);
    @(posedge clk);
    #1 tready = 1'b1;
    tick(1);
    tready = 1'b0;
    @(negedge clk);
    check("t3_last", tlast, 1);
    sd = tdata;
    sk = tkeep;
    stable = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (tdata !== sd || tkeep !== sk || !tlast || !tvalid)
        stable = 1'b0;
    end
    check("t3_stable1", stable, 1);
    @(posedge clk);
    #1 tready = 1'b1;
    settle("t3_idle");
    check("t3_nbeats", beats.size(), 2);
    check("t3_data", bd(1), 128'hA5);
    check("t3_ndone", done_q.size(), 1);

    // CQ value overwritten while pending behind SQ
    clear();
    req(1, 1, 16'h0001, 16'h0002);
    req(0, 1, 0, 16'h0009);
    wait_beats("t4_nbeats", 4);
    settle("t4_idle");
    tick(20);
    check("t4_total", beats.size(), 4);
    check("t4_cqaddr", bd(2) & 128'hFFFF_FFFF, 128'hF700_1004);
    check("t4_cqdata", bd(3), 9);
    check("t4_ndone", done_q.size(), 2);

    // async reset during beat 1
    clear();
    tready = 1'b0;
    req(1, 0, 16'h0004, 0);
    tready = 1'b1;
    tick(1);
    tready = 1'b0;
    check("t5_inbeat1", {tvalid, tlast}, 2'b11);
    #2 rst_n = 1'b0;
    #1;
    check("t5_valid", tvalid, 0);
    check("t5_busy", busy, 0);
    tick(1);
    rst_n = 1'b1;
    tready = 1'b1;
    tick(5);
    check("t5_ndone", done_q.size(), 0);

    // link-down flush during beat 1
    clear();
    tready = 1'b0;
    req(1, 0, 16'h0006, 0);
    tready = 1'b1;
    tick(1);
    tready = 1'b0;
    lnk = 1'b0;
    #1;
    check("t6_hold", tvalid, 1);
    tick(1);
    check("t6_valid", tvalid, 0);
    check("t6_busy", busy, 0);
    lnk = 1'b1;
    tready = 1'b1;
    tick(5);
    check("t6_ndone", done_q.size(), 0);
    check("t6_nbeats", beats.size(), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
